// File: rtl/ssp_pkg.sv
// Shared definitions for the SSP transmit path: FSM states, interrupt bit
// positions and default geometry.
package ssp_pkg;

  localparam int SSP_DATA_W     = 8;
  localparam int SSP_FIFO_DEPTH = 4;

  localparam int SSP_INT_FULL = 1;
  localparam int SSP_INT_HALF = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    SHIFT = 2'd2
  } ssp_state_e;

endpackage

// File: rtl/ssp_tx_fifo.sv
// Synchronous TX FIFO. A pop of an empty FIFO is ignored; a push into a full
// FIFO is accepted only when a pop frees a slot in the same cycle.
module ssp_tx_fifo
  import ssp_pkg::*;
#(
  parameter int  DATA_W     = SSP_DATA_W,
  parameter int  FIFO_DEPTH = SSP_FIFO_DEPTH,
  localparam int AW         = $clog2(FIFO_DEPTH),
  localparam int CW         = AW + 1
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rdata,
  output logic [CW-1:0]     o_count,
  output logic [CW-1:0]     o_count_nxt
);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic w_full;
  logic w_empty;
  logic w_pop_ok;
  logic w_push_ok;

  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_pop_ok  = i_pop & ~w_empty;
  assign w_push_ok = i_push & (~w_full | w_pop_ok);

  always_comb begin
    o_count_nxt = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   o_count_nxt = r_count + CW'(1);
      2'b01:   o_count_nxt = r_count - CW'(1);
      default: o_count_nxt = r_count;
    endcase
  end

  // Storage is never reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= o_count_nxt;
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/ssp_tx_ctrl.sv
// SSP transmitter: buffers host bytes and sends them MSB-first in TI-style
// frames timed by the CMU phi1/phi2 strobes.
module ssp_tx_ctrl
  import ssp_pkg::*;
#(
  parameter int DATA_W     = SSP_DATA_W,
  parameter int FIFO_DEPTH = SSP_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              phi1,
  input  logic              phi2,
  input  logic              psel,
  input  logic              pwrite,
  input  logic [DATA_W-1:0] pwdata,
  output logic              ssptxd,
  output logic              sspfssout,
  output logic              sspclkout,
  output logic              ssp_oe_b,
  output logic [1:0]        ssp_int_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  ssp_state_e        r_state;
  ssp_state_e        w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [BW-1:0]     r_bitcnt;
  logic [BW-1:0]     w_bitcnt_nxt;
  logic              r_txd;
  logic              w_txd_nxt;
  logic              r_fss;
  logic              w_fss_nxt;
  logic              r_oe_b;
  logic              w_oe_b_nxt;
  logic              r_sclk;
  logic              w_sclk_nxt;
  logic [1:0]        r_int;
  logic [1:0]        w_int_nxt;

  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_fifo_rdata;
  logic [CW-1:0]     w_fifo_count;
  logic [CW-1:0]     w_fifo_count_nxt;
  logic              w_fifo_has_data;

  assign w_push          = psel & pwrite;
  assign w_fifo_has_data = (w_fifo_count != '0);

  ssp_tx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .clear       (clear),
    .i_push      (w_push),
    .i_wdata     (pwdata),
    .i_pop       (w_pop),
    .o_rdata     (w_fifo_rdata),
    .o_count     (w_fifo_count),
    .o_count_nxt (w_fifo_count_nxt)
  );

  // Frame sequencing only advances on phi1; without it every output holds,
  // which is what makes a CMU hold freeze the link cleanly.
  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_bitcnt_nxt = r_bitcnt;
    w_txd_nxt    = r_txd;
    w_fss_nxt    = r_fss;
    w_oe_b_nxt   = r_oe_b;
    w_pop        = 1'b0;
    if (phi1) begin
      case (r_state)
        IDLE: begin
          if (w_fifo_has_data) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_fifo_rdata;
            w_fss_nxt   = 1'b1;
            w_oe_b_nxt  = 1'b0;
            w_state_nxt = SYNC;
          end
        end
        SYNC: begin
          w_txd_nxt    = r_shift[DATA_W-1];
          w_fss_nxt    = 1'b0;
          w_bitcnt_nxt = BW'(DATA_W - 1);
          w_state_nxt  = SHIFT;
        end
        SHIFT: begin
          if (r_bitcnt != '0) begin
            w_shift_nxt  = {r_shift[DATA_W-2:0], 1'b0};
            w_txd_nxt    = r_shift[DATA_W-2];
            w_bitcnt_nxt = r_bitcnt - BW'(1);
          end else if (w_fifo_has_data) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_fifo_rdata;
            w_fss_nxt   = 1'b1;
            w_txd_nxt   = 1'b0;
            w_state_nxt = SYNC;
          end else begin
            w_txd_nxt   = 1'b0;
            w_oe_b_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // Serial clock rises on phi1 and falls on phi2 while a frame is live; phi1 wins a tie.
  always_comb begin
    w_sclk_nxt = r_sclk;
    if (w_state_nxt == IDLE) begin
      w_sclk_nxt = 1'b0;
    end else if (phi1) begin
      w_sclk_nxt = 1'b1;
    end else if (phi2) begin
      w_sclk_nxt = 1'b0;
    end
  end

  always_comb begin
    w_int_nxt               = 2'b00;
    w_int_nxt[SSP_INT_FULL] = (w_fifo_count_nxt == CW'(FIFO_DEPTH));
    w_int_nxt[SSP_INT_HALF] = (w_fifo_count_nxt <= CW'(FIFO_DEPTH / 2));
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_txd    <= 1'b0;
      r_fss    <= 1'b0;
      r_oe_b   <= 1'b1;
      r_sclk   <= 1'b0;
      r_int    <= 2'b01;
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_txd    <= w_txd_nxt;
      r_fss    <= w_fss_nxt;
      r_oe_b   <= w_oe_b_nxt;
      r_sclk   <= w_sclk_nxt;
      r_int    <= w_int_nxt;
    end
  end

  assign ssptxd    = r_txd;
  assign sspfssout = r_fss;
  assign sspclkout = r_sclk;
  assign ssp_oe_b  = r_oe_b;
  assign ssp_int_o = r_int;

endmodule

// File: tb/tb_ssp_tx_ctrl.sv
// Bench for ssp_tx_ctrl: directed scenarios plus a randomized run, checked
// against a frame-level model of the FIFO and the serial symbol stream.
module tb_ssp_tx_ctrl;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              clear;
  logic              phi1;
  logic              phi2;
  logic              psel;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic              ssptxd;
  logic              sspfssout;
  logic              sspclkout;
  logic              ssp_oe_b;
  logic [1:0]        ssp_int_o;

  ssp_tx_ctrl #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .clear     (clear),
    .phi1      (phi1),
    .phi2      (phi2),
    .psel      (psel),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .ssptxd    (ssptxd),
    .sspfssout (sspfssout),
    .sspclkout (sspclkout),
    .ssp_oe_b  (ssp_oe_b),
    .ssp_int_o (ssp_int_o)
  );

  always #5 clk = ~clk;

  // One entry per bit period: what the pins should show during that period.
  typedef struct packed {
    logic fss;
    logic txd;
    logic oeb;
  } sym_t;

  sym_t              symQ[$];
  logic [DATA_W-1:0] mFifo[$];
  sym_t              curSym;
  logic              expSclk;
  int                phase;
  logic              phiEn;
  int                checkCount;
  int                errorCount;

  task automatic checkOutput(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checkCount++;
    assert (obs === exp)
    else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic void modelEdge(input logic doWrite, input logic [DATA_W-1:0] data,
                                    input logic doClear, input logic p1, input logic p2);
    int                preCount;
    bit                popped;
    logic [DATA_W-1:0] b;
    sym_t              s;
    if (doClear) begin
      mFifo.delete();
      symQ.delete();
      curSym  = '{fss: 1'b0, txd: 1'b0, oeb: 1'b1};
      expSclk = 1'b0;
      return;
    end
    preCount = mFifo.size();
    popped   = 1'b0;
    if (p1) begin
      if (symQ.size() == 0 && mFifo.size() > 0) begin
        b      = mFifo.pop_front();
        popped = 1'b1;
        s      = '{fss: 1'b1, txd: 1'b0, oeb: 1'b0};
        symQ.push_back(s);
        for (int i = DATA_W - 1; i >= 0; i--) begin
          s = '{fss: 1'b0, txd: b[i], oeb: 1'b0};
          symQ.push_back(s);
        end
      end
      if (symQ.size() > 0) curSym = symQ.pop_front();
      else curSym = '{fss: 1'b0, txd: 1'b0, oeb: 1'b1};
      expSclk = ~curSym.oeb;
    end else if (p2) begin
      expSclk = 1'b0;
    end
    if (doWrite && (preCount < DEPTH || popped)) mFifo.push_back(data);
  endfunction

  task automatic applyStimulus(input logic sel, input logic wr, input logic [DATA_W-1:0] data,
                               input logic doClear);
    logic p1;
    logic p2;
    p1     = phiEn && (phase == 0);
    p2     = phiEn && (phase == 2);
    psel   = sel;
    pwrite = wr;
    pwdata = data;
    clear  = doClear;
    phi1   = p1;
    phi2   = p2;
    @(posedge clk);
    modelEdge(sel & wr, data, doClear, p1, p2);
    phase = (phase + 1) % 4;
    #1;
    checkOutput("int", ssp_int_o, {mFifo.size() == DEPTH, mFifo.size() <= DEPTH / 2});
    checkOutput("txd", {1'b0, ssptxd}, {1'b0, curSym.txd});
    checkOutput("fss", {1'b0, sspfssout}, {1'b0, curSym.fss});
    checkOutput("oe_b", {1'b0, ssp_oe_b}, {1'b0, curSym.oeb});
    checkOutput("sclk", {1'b0, sspclkout}, {1'b0, expSclk});
  endtask

  task automatic idleTicks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic writeByte(input logic [DATA_W-1:0] data);
    applyStimulus(1'b1, 1'b1, data, 1'b0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (!(mFifo.size() == 0 && symQ.size() == 0 && curSym.oeb == 1'b1) && n < 400) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      n++;
    end
    checkOutput(tag, {1'b0, n < 400}, 2'b01);
  endtask

  task automatic runUntilRemaining(input int remaining, input string tag);
    int n = 0;
    while (!(symQ.size() == remaining && curSym.fss == 1'b0 && curSym.oeb == 1'b0) && n < 200) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      n++;
    end
    checkOutput(tag, {1'b0, n < 200}, 2'b01);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    phase      = 0;
    phiEn      = 1'b1;
    curSym     = '{fss: 1'b0, txd: 1'b0, oeb: 1'b1};
    expSclk    = 1'b0;

    $display("[TB] reset and single frame");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("reset_int", ssp_int_o, 2'b01);
    checkOutput("reset_oe_b", {1'b0, ssp_oe_b}, 2'b01);
    writeByte(8'hA5);
    drain("drain_a5");

    $display("[TB] fill to full with strobes stopped");
    phiEn = 1'b0;
    writeByte(8'h11);
    writeByte(8'h22);
    writeByte(8'h33);
    writeByte(8'h44);
    checkOutput("full_after4", ssp_int_o, 2'b10);
    writeByte(8'h55);
    checkOutput("full_after5", ssp_int_o, 2'b10);
    phiEn = 1'b1;
    drain("drain_fill");

    $display("[TB] back-to-back frames");
    phiEn = 1'b0;
    writeByte(8'hFF);
    writeByte(8'h00);
    phiEn = 1'b1;
    drain("drain_b2b");

    $display("[TB] push and pop at full");
    phiEn = 1'b0;
    writeByte(8'h01);
    writeByte(8'h02);
    writeByte(8'h03);
    writeByte(8'h04);
    while (phase != 0) applyStimulus(1'b0, 1'b0, '0, 1'b0);
    phiEn = 1'b1;
    writeByte(8'h66);
    checkOutput("pushpop_full", ssp_int_o, 2'b10);
    drain("drain_pushpop");

    $display("[TB] hold mid-frame");
    writeByte(8'hC3);
    runUntilRemaining(5, "reach_bit3");
    phiEn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      checkOutput("hold_txd", {1'b0, ssptxd}, 2'b00);
      checkOutput("hold_sclk", {1'b0, sspclkout}, 2'b01);
    end
    phiEn = 1'b1;
    drain("drain_hold");

    $display("[TB] reset mid-frame");
    writeByte(8'h5A);
    runUntilRemaining(4, "reach_bit4");
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("midreset_txd", {1'b0, ssptxd}, 2'b00);
    checkOutput("midreset_fss", {1'b0, sspfssout}, 2'b00);
    checkOutput("midreset_oe_b", {1'b0, ssp_oe_b}, 2'b01);
    checkOutput("midreset_int", ssp_int_o, 2'b01);
    idleTicks(40);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 29) == 0) phiEn = ~phiEn;
      applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
                    DATA_W'($urandom), $urandom_range(0, 199) == 0);
    end
    phiEn = 1'b1;
    drain("drain_random");

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/ssp_tx_ctrl.md
Name: ssp_tx_ctrl

Overview:
Transmit end of the SSP serial link. It buffers parallel bytes from the host bus in a small TX FIFO and serialises them MSB-first in TI-style synchronous frames. Bit timing comes from the phi1/phi2 strobes issued by the clock management unit. It drives the ssp_int bus back to the clock management unit; ssp_int_o[1] requests the hold state when the TX FIFO is full.

Parameters:
DATA_W, 8, frame width in bits
FIFO_DEPTH, 4, TX FIFO entries (power of two, >=2)

Ports:
clk  input  1  system clock; all state updates on posedge
clear  input  1  synchronous active-high reset
phi1  input  1  bit-period strobe, one clk wide; launches serial data
phi2  input  1  mid-bit strobe, one clk wide; falling edge of serial clock
psel  input  1  host select
pwrite  input  1  host write; push when psel&pwrite
pwdata  input  DATA_W  byte to transmit
ssptxd  output  1  serial data out
sspfssout  output  1  frame sync, high for the bit period before MSB
sspclkout  output  1  serial clock out
ssp_oe_b  output  1  active-low pad output enable
ssp_int_o  output  2  [1]=TX FIFO full (hold request), [0]=TX FIFO at most half full (TX interrupt)

Behaviour:
- Reset: clk and clear, synchronous active-high. When clear=1 at a posedge:
  - FIFO is emptied, FSM goes to IDLE, bit counter is 0.
  - Outputs: ssptxd=0, sspfssout=0, sspclkout=0, ssp_oe_b=1.
  - ssp_int_o=2'b01 (empty FIFO is at most half full).
  - clear overrides a push or pop in the same cycle.
  - Reset mid-frame aborts the frame; no partial bits follow.
- FIFO:
  - Push when psel&pwrite and not full.
  - A push while full is silently dropped, except when a pop occurs in the same cycle; then the push is accepted.
  - Pop and push in the same cycle with the FIFO empty: the pop is not taken, the push lands, and count=1.
  - Occupancy counter is $clog2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.
- ssp_int_o is registered and reflects the post-update count:
  - [1]=(count==FIFO_DEPTH).
  - [0]=(count<=FIFO_DEPTH/2).
- Serial clock:
  - sspclkout is set at a clk edge with phi1=1 and cleared at a clk edge with phi2=1, only while the FSM is not IDLE.
  - In IDLE it is held at 0.
  - phi1 and phi2 never coincide. If they do, phi1 wins.
- FSM (IDLE, SYNC, SHIFT). Transitions are evaluated only at clk edges with phi1=1; all other cycles hold state.
  - IDLE:
    - If count>0: pop the head into the shift register, sspfssout<=1, ssp_oe_b<=0, go to SYNC.
    - Otherwise all outputs stay idle.
  - SYNC:
    - ssptxd<=shift[DATA_W-1], sspfssout<=0, bitcnt<=DATA_W-1, go to SHIFT.
  - SHIFT, bitcnt>0:
    - Shift left one bit, ssptxd<=next bit, bitcnt--.
  - SHIFT, bitcnt==0 (LSB period ends), FIFO non-empty (back-to-back frames):
    - Pop, sspfssout<=1, go to SYNC.
    - ssptxd<=0 during the sync bit.
  - SHIFT, bitcnt==0, FIFO empty:
    - ssptxd<=0, ssp_oe_b<=1, go to IDLE.
- Latency:
  - Write into an empty idle block: sspfssout rises at the first phi1 edge after the push is registered.
  - The MSB appears one bit period (4 clk at the free-running CMU rate) later.
  - One frame occupies DATA_W+1 bit periods.
- Hold: while the CMU holds, phi1 and phi2 are absent, so the FSM, sspclkout and all serial outputs freeze at their current values.
  - Host pushes still proceed while held.
  - Transmission resumes exactly where it stopped on the next phi1; no bit is lost or repeated.

Decomposition:
- Shared package ssp_pkg:
  - FSM state typedef {IDLE, SYNC, SHIFT}.
  - Index constants SSP_INT_FULL=1 and SSP_INT_HALF=0.
  - Default DATA_W and FIFO_DEPTH.
- One sub-module, ssp_tx_fifo:
  - Synchronous FIFO with push/pop/full/empty/count.
  - Pop of an empty FIFO and push of a full FIFO without a simultaneous pop are both ignored.
- The FSM, serialiser and clock/sync generation stay in ssp_tx_ctrl.

Test Plan:
- Reset and single frame:
  - Stimulus: hold clear 3 cycles, then write 8'hA5 with phi1 every 4 clk.
  - Required: ssp_int_o=01 after reset; sspfssout high for exactly one bit period; ssptxd then carries 1,0,1,0,0,1,0,1 on successive phi1 edges; ssp_oe_b returns high after the LSB period.
- Fill to full:
  - Stimulus: write 5 bytes (11,22,33,44,55) back-to-back with phi strobes stopped.
  - Required: ssp_int_o[1]=1 after the 4th write; the 5th write is dropped; only 11..44 are transmitted once phi resumes.
- Back-to-back frames:
  - Stimulus: queue 8'hFF and 8'h00.
  - Required: sspfssout re-asserts immediately after the LSB of FF, with no IDLE gap; frame 2 is all zeros.
- Push and pop at full:
  - Stimulus: FIFO full; write 8'h66 in the same cycle the FSM pops.
  - Required: the write is accepted; 8'h66 is transmitted last; count stays 4.
- Hold mid-frame:
  - Stimulus: suppress phi1/phi2 for 20 clk after the 3rd bit of 8'hC3.
  - Required: ssptxd and sspclkout stay frozen; the remaining bits 0,0,0,1,1 resume with no loss.
- Reset mid-frame:
  - Stimulus: assert clear during bit 4 of a frame.
  - Required: next cycle ssptxd=0, sspfssout=0, ssp_oe_b=1, ssp_int_o=01, and no further frame bits.
